traffic_light_fsm: RTL

//  Two-road traffic-light controller with pedestrian request, for the Basys FSM bonus design.

---
 rtl/traffic_light_fsm.sv | 104 ++++++++++
 1 files changed

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: two-road traffic-light controller with a pedestrian walk phase
//   Ports:
//     in_clk_i       board clock, the only clock
//     reset_i        synchronous active-high reset
//     slow_clk_i     divided square wave, sampled as data; its rising edge is a tick
//     ped_btn_i      raw asynchronous pedestrian button
//     light_ns_o     NS lamps {R,Y,G}, one-hot
//     light_ew_o     EW lamps {R,Y,G}, one-hot
//     walk_o         pedestrian walk lamp
//     ped_pending_o  latched pedestrian request not yet served
//     state_o        current state code for debug
module traffic_light_fsm #(
   parameter int GREEN_TICKS  = 5,
   parameter int YELLOW_TICKS = 2,
   parameter int ALLRED_TICKS = 1,
   parameter int WALK_TICKS   = 4,
   parameter int TW           = 4
) (
   input  logic       in_clk_i,
   input  logic       reset_i,
   input  logic       slow_clk_i,
   input  logic       ped_btn_i,
   output logic [2:0] light_ns_o,
   output logic [2:0] light_ew_o,
   output logic       walk_o,
   output logic       ped_pending_o,
   output logic [2:0] state_o
);
   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_1 = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_2 = 3'd5,
      WALK      = 3'd6,
      ILLEGAL   = 3'd7
   } state_t;

   state_t        state_q, state_d, nxt;
   logic [TW-1:0] cnt_q, cnt_d, dur;
   logic          slow_d_q, ps1_q, ps2_q, ps3_q, ped_q, ped_d;
   logic          tick, ped_edge, last;

   assign tick     = slow_clk_i & ~slow_d_q;
   assign ped_edge = ps2_q & ~ps3_q;
   assign dur      = (state_q == NS_GREEN  || state_q == EW_GREEN)  ? TW'(GREEN_TICKS)  :
                     (state_q == NS_YELLOW || state_q == EW_YELLOW) ? TW'(YELLOW_TICKS) :
                     (state_q == WALK)                              ? TW'(WALK_TICKS)   :
                                                                      TW'(ALLRED_TICKS);
   assign last     = cnt_q == dur - TW'(1);
   assign nxt      = state_q == NS_GREEN  ? NS_YELLOW :
                     state_q == NS_YELLOW ? ALL_RED_1 :
                     state_q == ALL_RED_1 ? EW_GREEN  :
                     state_q == EW_GREEN  ? EW_YELLOW :
                     state_q == EW_YELLOW ? ALL_RED_2 :
                     state_q == ALL_RED_2 ? (ped_q ? WALK : NS_GREEN) :
                                            NS_GREEN;

   always_ff @(posedge in_clk_i) begin
      if (reset_i) begin
         state_q  <= NS_GREEN;
         cnt_q    <= '0;
         slow_d_q <= 1'b0;
         ps1_q    <= 1'b0;
         ps2_q    <= 1'b0;
         ps3_q    <= 1'b0;
         ped_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         slow_d_q <= slow_clk_i;
         ps1_q    <= ped_btn_i;
         ps2_q    <= ps1_q;
         ps3_q    <= ps2_q;
         ped_q    <= ped_d;
      end
   end

   // Illegal code recovers unconditionally, without waiting for a tick.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ILLEGAL) begin
         state_d = NS_GREEN;
         cnt_d   = '0;
      end else if (tick) begin
         state_d = last ? nxt : state_q;
         cnt_d   = last ? '0 : cnt_q + TW'(1);
      end
   end

   // Entering WALK serves the request and swallows any press in that same cycle.
   assign ped_d = (state_d == WALK && state_q != WALK) ? 1'b0 :
                  (ped_edge && state_q != WALK)        ? 1'b1 : ped_q;

   always_comb begin
      light_ns_o    = state_q == NS_GREEN  ? 3'b001 : state_q == NS_YELLOW ? 3'b010 : 3'b100;
      light_ew_o    = state_q == EW_GREEN  ? 3'b001 : state_q == EW_YELLOW ? 3'b010 : 3'b100;
      walk_o        = state_q == WALK;
      ped_pending_o = ped_q;
      state_o       = state_q;
   end
endmodule
